// File: rtl/poly_bram_streamer.sv
// rtl/poly_bram_streamer.sv - drains an N-coefficient polynomial from banks 0/1 as a 4-coefficient-per-beat stream
// Credit-limited BRAM reads feed a small FIFO so backpressure never drops read data.
module poly_bram_streamer #(
   parameter int N            = 16,
   parameter int K            = 32,
   parameter int READ_LATENCY = 1,
   parameter int FIFO_DEPTH   = 4,
   localparam int AW          = $clog2(N / 2)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   output logic [3:0]        o_bram_en,
   output logic [3:0]        o_bram_we,
   output logic [4*AW-1:0]   o_bram_addr_a,
   output logic [4*AW-1:0]   o_bram_addr_b,
   output logic [4*K-1:0]    o_bram_di_a,
   output logic [4*K-1:0]    o_bram_di_b,
   input  logic [2*K-1:0]    i_bram_do_a,
   input  logic [2*K-1:0]    i_bram_do_b,
   output logic [4*K-1:0]    o_out_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic              o_out_last,
   output logic              o_busy,
   output logic              o_done
);

   localparam int NB = N / 4;
   localparam int CW = $clog2(NB + 1);
   localparam int OW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [CW-1:0]           r_rd_cnt;
   logic [CW-1:0]           r_out_cnt;
   logic [READ_LATENCY-1:0] r_vsr;
   logic [OW-1:0]           r_inflight;
   logic [OW-1:0]           r_count;
   logic [4*K-1:0]          r_mem [FIFO_DEPTH];
   logic [PW-1:0]           r_wptr;
   logic [PW-1:0]           r_rptr;

   logic                    w_credit;
   logic                    w_issue;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_last_issue;
   logic                    w_last_pop;
   logic [AW-1:0]           w_addr_a;
   logic [AW-1:0]           w_addr_b;

   // Credit uses occupancy before this cycle's pop, so a push can never find the FIFO full.
   assign w_credit     = ({1'b0, r_count} + {1'b0, r_inflight}) < (OW + 1)'(FIFO_DEPTH);
   assign w_push       = r_vsr[READ_LATENCY-1];
   assign w_pop        = o_out_valid & i_out_ready;
   assign w_last_issue = w_issue && (r_rd_cnt == CW'(NB - 1));
   assign w_last_pop   = w_pop && o_out_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_READ;
         S_READ:  if (w_last_issue) w_next = S_DRAIN;
         S_DRAIN: if (w_last_pop) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy  = 1'b0;
      o_done  = 1'b0;
      w_issue = 1'b0;
      case (r_state)
         S_READ: begin
            o_busy  = 1'b1;
            w_issue = !reset && w_credit && (r_rd_cnt < CW'(NB));
         end
         S_DRAIN: o_busy = 1'b1;
         S_DONE:  o_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_cnt   <= '0;
         r_out_cnt  <= '0;
         r_vsr      <= '0;
         r_inflight <= '0;
      end else begin
         if (r_state == S_IDLE && i_start) begin
            r_rd_cnt  <= '0;
            r_out_cnt <= '0;
         end else begin
            if (w_issue) r_rd_cnt <= r_rd_cnt + CW'(1);
            if (w_pop && r_out_cnt != CW'(NB - 1)) r_out_cnt <= r_out_cnt + CW'(1);
         end
         r_vsr[0] <= w_issue;
         for (int i = 1; i < READ_LATENCY; i++) r_vsr[i] <= r_vsr[i-1];
         r_inflight <= r_inflight + OW'(w_issue) - OW'(w_push);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= (r_wptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
         if (w_pop)  r_rptr <= (r_rptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + OW'(1);
            2'b01:   r_count <= r_count - OW'(1);
            default: ;
         endcase
      end
   end

   // Beat layout {c3,c2,c1,c0} = {bank1.do_b, bank0.do_b, bank1.do_a, bank0.do_a}.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= {i_bram_do_b, i_bram_do_a};
   end

   assign o_out_valid = (r_count != '0);
   assign o_out_data  = r_mem[r_rptr];
   assign o_out_last  = o_out_valid && (r_out_cnt == CW'(NB - 1));

   assign w_addr_a      = AW'({r_rd_cnt, 1'b0});
   assign w_addr_b      = AW'({r_rd_cnt, 1'b1});
   assign o_bram_en     = {2'b00, w_issue, w_issue};
   assign o_bram_we     = 4'b0000;
   assign o_bram_addr_a = {{(2*AW){1'b0}}, w_addr_a, w_addr_a};
   assign o_bram_addr_b = {{(2*AW){1'b0}}, w_addr_b, w_addr_b};
   assign o_bram_di_a   = '0;
   assign o_bram_di_b   = '0;

endmodule

// File: tb/tb_poly_bram_streamer.sv
// tb/tb_poly_bram_streamer.sv - self-checking bench for poly_bram_streamer
// Two instances: N=16/RL=1/FD=4 and N=64/RL=2/FD=3, each with a behavioural BRAM.
module tb_poly_bram_streamer;

   localparam int K    = 32;
   localparam int A_N  = 16;
   localparam int A_RL = 1;
   localparam int A_FD = 4;
   localparam int A_AW = 3;
   localparam int B_N  = 64;
   localparam int B_RL = 2;
   localparam int B_FD = 3;
   localparam int B_AW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, start, ready, sel, mon_on;
   logic [31:0] a_c [A_N];
   logic [31:0] b_c [B_N];

   logic              a_start, a_ready, a_valid, a_last, a_busy, a_done;
   logic [3:0]        a_en, a_we;
   logic [4*A_AW-1:0] a_addr_a, a_addr_b;
   logic [4*K-1:0]    a_di_a, a_di_b, a_data;
   logic [2*K-1:0]    a_do_a, a_do_b;

   logic              b_start, b_ready, b_valid, b_last, b_busy, b_done;
   logic [3:0]        b_en, b_we;
   logic [4*B_AW-1:0] b_addr_a, b_addr_b;
   logic [4*K-1:0]    b_di_a, b_di_b, b_data;
   logic [2*K-1:0]    b_do_a, b_do_b, b_s_a, b_s_b;

   assign a_start = start & ~sel;
   assign b_start = start & sel;
   assign a_ready = sel ? 1'b1 : ready;
   assign b_ready = sel ? ready : 1'b1;

   poly_bram_streamer #(.N(A_N), .K(K), .READ_LATENCY(A_RL), .FIFO_DEPTH(A_FD)) dut_a (
      .clk(clk), .reset(reset), .i_start(a_start),
      .o_bram_en(a_en), .o_bram_we(a_we), .o_bram_addr_a(a_addr_a), .o_bram_addr_b(a_addr_b),
      .o_bram_di_a(a_di_a), .o_bram_di_b(a_di_b), .i_bram_do_a(a_do_a), .i_bram_do_b(a_do_b),
      .o_out_data(a_data), .o_out_valid(a_valid), .i_out_ready(a_ready), .o_out_last(a_last),
      .o_busy(a_busy), .o_done(a_done));

   poly_bram_streamer #(.N(B_N), .K(K), .READ_LATENCY(B_RL), .FIFO_DEPTH(B_FD)) dut_b (
      .clk(clk), .reset(reset), .i_start(b_start),
      .o_bram_en(b_en), .o_bram_we(b_we), .o_bram_addr_a(b_addr_a), .o_bram_addr_b(b_addr_b),
      .o_bram_di_a(b_di_a), .o_bram_di_b(b_di_b), .i_bram_do_a(b_do_a), .i_bram_do_b(b_do_b),
      .o_out_data(b_data), .o_out_valid(b_valid), .i_out_ready(b_ready), .o_out_last(b_last),
      .o_busy(b_busy), .o_done(b_done));

   // Bank j holds coefficient 2*addr+j.
   always @(posedge clk) begin
      if (a_en[0]) begin
         a_do_a[31:0] <= a_c[2*a_addr_a[2:0]];
         a_do_b[31:0] <= a_c[2*a_addr_b[2:0]];
      end
      if (a_en[1]) begin
         a_do_a[63:32] <= a_c[2*a_addr_a[5:3]+1];
         a_do_b[63:32] <= a_c[2*a_addr_b[5:3]+1];
      end
      if (b_en[0]) begin
         b_s_a[31:0] <= b_c[2*b_addr_a[4:0]];
         b_s_b[31:0] <= b_c[2*b_addr_b[4:0]];
      end
      if (b_en[1]) begin
         b_s_a[63:32] <= b_c[2*b_addr_a[9:5]+1];
         b_s_b[63:32] <= b_c[2*b_addr_b[9:5]+1];
      end
      b_do_a <= b_s_a;
      b_do_b <= b_s_b;
   end

   logic         v_valid, v_last, v_busy, v_done, v_en0;
   logic [127:0] v_data;
   assign v_valid = sel ? b_valid : a_valid;
   assign v_last  = sel ? b_last  : a_last;
   assign v_busy  = sel ? b_busy  : a_busy;
   assign v_done  = sel ? b_done  : a_done;
   assign v_en0   = sel ? b_en[0] : a_en[0];
   assign v_data  = sel ? b_data  : a_data;

   int mon_err = 0;
   always @(negedge clk) begin
      if (mon_on) begin
         assert (a_en[3:2] === 2'b00 && b_en[3:2] === 2'b00 && a_we === 4'b0 && b_we === 4'b0) else begin
            mon_err++;
            $error("FAIL bank_monitor_en_we: a_en=%b a_we=%b b_en=%b b_we=%b required en[3:2]=00 we=0000",
                   a_en, a_we, b_en, b_we);
         end
         assert (a_di_a === '0 && a_di_b === '0 && b_di_a === '0 && b_di_b === '0 &&
                 a_addr_a[4*A_AW-1:2*A_AW] === '0 && a_addr_b[4*A_AW-1:2*A_AW] === '0 &&
                 b_addr_a[4*B_AW-1:2*B_AW] === '0 && b_addr_b[4*B_AW-1:2*B_AW] === '0) else begin
            mon_err++;
            $error("FAIL bank_monitor_di_addr: a_di_a=%0h a_di_b=%0h b_di_a=%0h b_di_b=%0h required all zero",
                   a_di_a, a_di_b, b_di_a, b_di_b);
         end
      end
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_data(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%032h expected 0x%032h", tag, obs, exp);
   endtask

   function automatic logic [127:0] exp_beat(input int b);
      if (sel) return {b_c[4*b+3], b_c[4*b+2], b_c[4*b+1], b_c[4*b]};
      return {a_c[4*b+3], a_c[4*b+2], a_c[4*b+1], a_c[4*b]};
   endfunction

   logic [127:0] obs_data [$];
   int           obs_cyc  [$];
   logic         obs_last [$];
   int           done_n, done_cyc, issue_n, issue_early, hold_err, credit_err;
   logic [63:0]  busy_mask;

   // rmode: 0 ready always high, 1 ready low through cycle 10, 2 ready random 50%.
   task automatic run(input int rmode, input logic [63:0] start_mask, input int budget);
      logic         prev_stall = 1'b0;
      logic [127:0] prev_data = '0;
      logic         prev_last = 1'b0;
      int           outstanding = 0;
      int           fd = sel ? B_FD : A_FD;
      obs_data.delete(); obs_cyc.delete(); obs_last.delete();
      done_n = 0; done_cyc = -1; issue_n = 0; issue_early = 0;
      hold_err = 0; credit_err = 0; busy_mask = '0;
      for (int c = 0; c < budget; c++) begin
         start = (c < 64) ? start_mask[c] : 1'b0;
         case (rmode)
            0:       ready = 1'b1;
            1:       ready = (c > 10);
            default: ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (c < 64 && v_busy) busy_mask[c] = 1'b1;
         if (v_done) begin
            done_n++;
            done_cyc = c;
         end
         if (v_en0) begin
            issue_n++;
            outstanding++;
            if (c <= 10) issue_early++;
         end
         if (outstanding > fd) credit_err++;
         if (prev_stall && (v_data !== prev_data || v_last !== prev_last)) hold_err++;
         if (v_valid && ready) begin
            obs_data.push_back(v_data);
            obs_cyc.push_back(c);
            obs_last.push_back(v_last);
            outstanding--;
         end
         prev_stall = v_valid && !ready;
         prev_data  = v_data;
         prev_last  = v_last;
         @(negedge clk);
         if (done_n != 0 && c >= done_cyc + 2) break;
      end
      start = 1'b0;
      ready = 1'b1;
   endtask

   task automatic verify_stream(input string tag);
      int nb = sel ? B_N / 4 : A_N / 4;
      int n_last = 0;
      check_int({tag, "_beat_count"}, obs_data.size(), nb);
      for (int i = 0; i < obs_data.size() && i < nb; i++)
         check_data($sformatf("%s_beat%0d", tag, i), obs_data[i], exp_beat(i));
      foreach (obs_last[i]) if (obs_last[i]) n_last++;
      check_int({tag, "_last_count"}, n_last, 1);
      if (obs_last.size() != 0) check_bit({tag, "_last_on_final"}, obs_last[obs_last.size()-1], 1'b1);
      check_int({tag, "_done_count"}, done_n, 1);
      check_int({tag, "_issue_count"}, issue_n, nb);
      check_int({tag, "_hold_errors"}, hold_err, 0);
      check_int({tag, "_credit_errors"}, credit_err, 0);
   endtask

   initial begin
      sel = 1'b0; start = 1'b0; ready = 1'b1; reset = 1'b1; mon_on = 1'b0;
      for (int i = 0; i < A_N; i++) a_c[i] = 32'(i + 1);
      for (int i = 0; i < B_N; i++) b_c[i] = $urandom;

      repeat (3) @(negedge clk);
      #1;
      mon_on = 1'b1;
      check_bit("reset_a_valid", a_valid, 1'b0);
      check_bit("reset_a_last", a_last, 1'b0);
      check_bit("reset_a_busy", a_busy, 1'b0);
      check_bit("reset_a_done", a_done, 1'b0);
      check_int("reset_a_en", int'(a_en), 0);
      check_bit("reset_b_valid", b_valid, 1'b0);
      check_int("reset_b_en", int'(b_en), 0);
      reset = 1'b0;
      @(negedge clk);

      // Free-flowing readout
      run(0, 64'h1, 20);
      verify_stream("flow");
      if (obs_cyc.size() == 4) begin
         check_int("flow_first_cycle", obs_cyc[0], 3);
         check_int("flow_last_cycle", obs_cyc[3], 6);
      end
      check_int("flow_done_cycle", done_cyc, 7);
      check_data("flow_busy_mask", 128'(busy_mask), 128'h7E);

      // Consumer stalled through cycle 10
      run(1, 64'h1, 40);
      verify_stream("stall");
      check_int("stall_reads_while_stalled", issue_early, A_FD);
      if (obs_cyc.size() != 0) check_int("stall_first_cycle", obs_cyc[0], 11);
      check_int("stall_done_cycle", done_cyc, 15);

      // Random backpressure on the deep-latency, shallow-FIFO instance
      sel = 1'b1;
      @(negedge clk);
      run(2, 64'h1, 600);
      verify_stream("random");
      sel = 1'b0;
      @(negedge clk);

      // Extra starts during READ and in the DONE cycle
      run(0, 64'h85, 20);
      verify_stream("restart_ignored");
      check_data("restart_busy_mask", 128'(busy_mask), 128'h7E);

      // Reset in the cycle after beat 1 transfers
      start = 1'b1; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_bit("midreset_beat1_valid", a_valid, 1'b1);
      check_data("midreset_beat1_data", a_data, exp_beat(1));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_bit("midreset_valid", a_valid, 1'b0);
      check_bit("midreset_busy", a_busy, 1'b0);
      check_int("midreset_en", int'(a_en), 0);
      @(negedge clk);
      run(0, 64'h1, 20);
      verify_stream("after_reset");

      repeat (2) @(negedge clk);
      check_int("bank_monitor_errors", mon_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
